// File: rtl/ex_issue.sv
// Decode-to-execute issue register: captures one decoded instruction, forwards and
// snoops the writeback port, and holds multiply operands for a multicycle EX path.
module ex_issue #(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 2
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [3:0]      id_op,
  input  logic [4:0]      id_rs1_idx,
  input  logic [4:0]      id_rs2_idx,
  input  logic [XLEN-1:0] id_rs1_val,
  input  logic [XLEN-1:0] id_rs2_val,
  input  logic            id_use_imm,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rd,
  input  logic            id_rd_wen,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic            ex_busy,
  output logic [3:0]      ex_op,
  output logic [XLEN-1:0] ex_a,
  output logic [XLEN-1:0] ex_b,
  output logic [4:0]      ex_rd,
  output logic            ex_rd_wen,
  output logic            ex_signed_a,
  output logic            ex_signed_b,
  output logic            ex_mul_hi,
  output logic            ex_illegal
);

  localparam logic [3:0] OP_ADD    = 4'd0;
  localparam logic [3:0] OP_MUL    = 4'd7;
  localparam logic [3:0] OP_MULH   = 4'd8;
  localparam logic [3:0] OP_MULHSU = 4'd9;
  localparam logic [3:0] OP_MULHU  = 4'd10;
  localparam logic [1:0] CNT_LOAD  = 2'(MUL_LAT - 1);
  localparam bit         MUL_MULTI = (MUL_LAT > 1);

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    ALU_HOLD = 2'd1,
    MUL_WAIT = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;

  logic [3:0]      op_q;
  logic [XLEN-1:0] a_q, b_q;
  logic [4:0]      rd_q, rs1_q, rs2_q;
  logic            rd_wen_q, sa_q, sb_q, hi_q, ill_q, use_imm_q;

  logic [3:0]      dec_op;
  logic            dec_mul, dec_sa, dec_sb, dec_hi, dec_ill, dec_rd_wen;
  logic [XLEN-1:0] cap_a, cap_b;
  logic            held, snoop_a, snoop_b, accept;

  // Register read with writeback bypass; x0 is hardwired to zero.
  function automatic logic [XLEN-1:0] read_src(
    input logic [4:0]      idx,
    input logic [XLEN-1:0] rf_val,
    input logic            fwd_valid,
    input logic [4:0]      fwd_rd,
    input logic [XLEN-1:0] fwd_data
  );
    if (idx == 5'd0) return '0;
    if (fwd_valid && (fwd_rd == idx)) return fwd_data;
    return rf_val;
  endfunction

  // NOTE: every signal assigned in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    dec_op     = id_op;
    dec_mul    = 1'b0;
    dec_sa     = 1'b0;
    dec_sb     = 1'b0;
    dec_hi     = 1'b0;
    dec_ill    = 1'b0;
    dec_rd_wen = id_rd_wen;
    case (id_op)
      OP_MUL:    dec_mul = 1'b1;
      OP_MULH:   begin dec_mul = 1'b1; dec_sa = 1'b1; dec_sb = 1'b1; dec_hi = 1'b1; end
      OP_MULHSU: begin dec_mul = 1'b1; dec_sa = 1'b1; dec_hi = 1'b1; end
      OP_MULHU:  begin dec_mul = 1'b1; dec_hi = 1'b1; end
      default: begin
        if (id_op > OP_MULHU) begin
          dec_op     = OP_ADD;
          dec_ill    = 1'b1;
          dec_rd_wen = 1'b0;
        end
      end
    endcase
  end

  assign cap_a = read_src(id_rs1_idx, id_rs1_val, wb_valid, wb_rd, wb_data);
  assign cap_b = id_use_imm ? id_imm
                            : read_src(id_rs2_idx, id_rs2_val, wb_valid, wb_rd, wb_data);

  // An instruction is still held (and snoopable) until the cycle EX consumes it.
  assign held    = (state_q == MUL_WAIT) || ((state_q == ALU_HOLD) && !ex_ready);
  assign snoop_a = held && wb_valid && (wb_rd == rs1_q) && (rs1_q != 5'd0);
  assign snoop_b = held && wb_valid && !use_imm_q && (wb_rd == rs2_q) && (rs2_q != 5'd0);

  assign id_ready = reset_n && ((state_q == EMPTY) || ((state_q == ALU_HOLD) && ex_ready));
  assign accept   = id_valid && id_ready && !flush;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      EMPTY: ;
      ALU_HOLD: if (ex_ready) state_d = EMPTY;
      MUL_WAIT: begin
        if (snoop_a || snoop_b) begin
          cnt_d = CNT_LOAD;
        end else if (cnt_q <= 2'd1) begin
          state_d = ALU_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (accept) begin
      state_d = (dec_mul && MUL_MULTI) ? MUL_WAIT : ALU_HOLD;
      cnt_d   = CNT_LOAD;
    end
    if (flush) begin
      state_d = EMPTY;
      cnt_d   = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= EMPTY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: the payload is a handful of flops, not a memory, so resetting it is cheap
  // and keeps the outputs at zero right after reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rd_q      <= '0;
      rd_wen_q  <= 1'b0;
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      hi_q      <= 1'b0;
      ill_q     <= 1'b0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      use_imm_q <= 1'b0;
    end else if (accept) begin
      op_q      <= dec_op;
      a_q       <= cap_a;
      b_q       <= cap_b;
      rd_q      <= id_rd;
      rd_wen_q  <= dec_rd_wen;
      sa_q      <= dec_sa;
      sb_q      <= dec_sb;
      hi_q      <= dec_hi;
      ill_q     <= dec_ill;
      rs1_q     <= id_rs1_idx;
      rs2_q     <= id_rs2_idx;
      use_imm_q <= id_use_imm;
    end else if (!flush) begin
      if (snoop_a) a_q <= wb_data;
      if (snoop_b) b_q <= wb_data;
    end
  end

  // Outputs are gated by reset_n so they read zero for the whole reset window,
  // not just after the first reset edge.
  assign ex_valid    = reset_n && (state_q == ALU_HOLD);
  assign ex_busy     = reset_n && (state_q == MUL_WAIT);
  assign ex_op       = reset_n ? op_q : '0;
  assign ex_a        = reset_n ? a_q : '0;
  assign ex_b        = reset_n ? b_q : '0;
  assign ex_rd       = reset_n ? rd_q : '0;
  assign ex_rd_wen   = reset_n && rd_wen_q;
  assign ex_signed_a = reset_n && sa_q;
  assign ex_signed_b = reset_n && sb_q;
  assign ex_mul_hi   = reset_n && hi_q;
  assign ex_illegal  = reset_n && ill_q;

endmodule

// File: tb/tb_ex_issue.sv
// Bench for ex_issue: table of decoded instructions with a result scoreboard,
// plus hand-written sequences for snoop, flush, reset and back-to-back issue.
module tb_ex_issue;
  localparam int MUL_LAT = 2;

  logic        clock = 1'b0;
  logic        reset_n, flush, id_valid, id_use_imm, id_rd_wen, wb_valid, ex_ready;
  logic [3:0]  id_op;
  logic [4:0]  id_rs1_idx, id_rs2_idx, id_rd, wb_rd;
  logic [31:0] id_rs1_val, id_rs2_val, id_imm, wb_data;
  logic        id_ready, ex_valid, ex_busy, ex_rd_wen, ex_signed_a, ex_signed_b;
  logic        ex_mul_hi, ex_illegal;
  logic [3:0]  ex_op;
  logic [31:0] ex_a, ex_b;
  logic [4:0]  ex_rd;

  always #5 clock = ~clock;

  ex_issue #(.XLEN(32), .MUL_LAT(MUL_LAT)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready), .id_op(id_op),
    .id_rs1_idx(id_rs1_idx), .id_rs2_idx(id_rs2_idx),
    .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val),
    .id_use_imm(id_use_imm), .id_imm(id_imm), .id_rd(id_rd), .id_rd_wen(id_rd_wen),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_busy(ex_busy),
    .ex_op(ex_op), .ex_a(ex_a), .ex_b(ex_b), .ex_rd(ex_rd), .ex_rd_wen(ex_rd_wen),
    .ex_signed_a(ex_signed_a), .ex_signed_b(ex_signed_b),
    .ex_mul_hi(ex_mul_hi), .ex_illegal(ex_illegal)
  );

  // Expected result fields; flags are {rd_wen, signed_a, signed_b, mul_hi, illegal}.
  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [4:0]  flags;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rs1, rs2, rd, wbrd;
    logic [31:0] v1, v2, imm, wbd;
    logic        use_imm, wbv;
    exp_t        want;
    int          lat;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[14];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
  endtask

  function automatic vec_t mk(
    input logic [3:0] op, input logic [4:0] rs1, input logic [31:0] v1,
    input logic [4:0] rs2, input logic [31:0] v2, input logic use_imm, input logic [31:0] imm,
    input logic wbv, input logic [4:0] wbrd, input logic [31:0] wbd, input logic [4:0] rd,
    input logic [3:0] eop, input logic [31:0] ea, input logic [31:0] eb,
    input logic [4:0] eflags, input int lat);
    vec_t v;
    v.op = op; v.rs1 = rs1; v.v1 = v1; v.rs2 = rs2; v.v2 = v2;
    v.use_imm = use_imm; v.imm = imm; v.wbv = wbv; v.wbrd = wbrd; v.wbd = wbd; v.rd = rd;
    v.want = {eop, ea, eb, rd, eflags};
    v.lat = lat;
    return v;
  endfunction

  function automatic exp_t observed();
    return {ex_op, ex_a, ex_b, ex_rd, ex_rd_wen, ex_signed_a, ex_signed_b, ex_mul_hi, ex_illegal};
  endfunction

  function automatic logic [80:0] all_outputs();
    return {id_ready, ex_valid, ex_busy, ex_op, ex_a, ex_b, ex_rd, ex_rd_wen,
            ex_signed_a, ex_signed_b, ex_mul_hi, ex_illegal};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_id(input vec_t v);
    id_op = v.op; id_rs1_idx = v.rs1; id_rs1_val = v.v1; id_rs2_idx = v.rs2; id_rs2_val = v.v2;
    id_use_imm = v.use_imm; id_imm = v.imm; id_rd = v.rd; id_rd_wen = 1'b1;
    wb_valid = v.wbv; wb_rd = v.wbrd; wb_data = v.wbd;
  endtask

  // Scoreboard: every consumed result is compared with the oldest expected entry.
  always @(negedge clock) begin
    exp_t e;
    if (reset_n && ex_valid && ex_ready) begin
      check("scoreboard_has_entry", sb_q.size() != 0, 1'b1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("ex_fields", observed(), e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t v;
    exp_t e;
    int   lat;
    logic [5:0] pat;

    //            op  rs1 v1            rs2 v2          imm imm_val      wbv wbrd wbd           rd  eop ea            eb            flags     lat
    vecs[0]  = mk(0,  1,  32'd5,        2,  32'd7,      0,  0,           0,  0,   0,            3,  0,  32'd5,        32'd7,        5'b10000, 1);
    vecs[1]  = mk(1,  1,  32'd3,        2,  32'd9,      0,  0,           1,  1,   32'h100,      4,  1,  32'h100,      32'd9,        5'b10000, 1);
    vecs[2]  = mk(1,  0,  32'd3,        2,  32'd9,      0,  0,           1,  0,   32'h100,      5,  1,  32'h0,        32'd9,        5'b10000, 1);
    vecs[3]  = mk(2,  3,  32'h80000000, 7,  32'd1,      1,  32'hFFFFFFF0, 1, 7,   32'h999,      6,  2,  32'h80000000, 32'hFFFFFFF0, 5'b10000, 1);
    vecs[4]  = mk(3,  4,  32'd1,        0,  32'h1234,   0,  0,           0,  0,   0,            7,  3,  32'd1,        32'h0,        5'b10000, 1);
    vecs[5]  = mk(4,  5,  32'd3,        4,  32'd1,      0,  0,           1,  4,   32'hDEAD,     8,  4,  32'd3,        32'hDEAD,     5'b10000, 1);
    vecs[6]  = mk(5,  6,  32'hF0F0,     8,  32'd4,      0,  0,           1,  9,   32'h77,       9,  5,  32'hF0F0,     32'd4,        5'b10000, 1);
    vecs[7]  = mk(6,  6,  32'd1,        8,  32'd31,     0,  0,           1,  6,   32'h80000000, 10, 6,  32'h80000000, 32'd31,       5'b10000, 1);
    vecs[8]  = mk(7,  10, 32'h1234,     11, 32'h10,     0,  0,           0,  0,   0,            11, 7,  32'h1234,     32'h10,       5'b10000, MUL_LAT);
    vecs[9]  = mk(8,  12, 32'hFFFFFFFD, 13, 32'd7,      0,  0,           0,  0,   0,            12, 8,  32'hFFFFFFFD, 32'd7,        5'b11110, MUL_LAT);
    vecs[10] = mk(9,  14, 32'hFFFFFFFF, 15, 32'd2,      0,  0,           0,  0,   0,            13, 9,  32'hFFFFFFFF, 32'd2,        5'b11010, MUL_LAT);
    vecs[11] = mk(10, 16, 32'd5,        17, 32'd6,      0,  0,           1,  17,  32'hABCD,     14, 10, 32'd5,        32'hABCD,     5'b10010, MUL_LAT);
    vecs[12] = mk(12, 18, 32'h11,       19, 32'h22,     0,  0,           0,  0,   0,            15, 0,  32'h11,       32'h22,       5'b00001, 1);
    vecs[13] = mk(15, 20, 32'h33,       0,  32'h44,     1,  32'h8,       0,  0,   0,            16, 0,  32'h33,       32'h8,        5'b00001, 1);

    reset_n = 1'b0; flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b1;
    drive_id(vecs[0]);
    wb_valid = 1'b0;
    repeat (3) tick();
    check("reset_outputs_zero", all_outputs(), '0);
    reset_n = 1'b1;
    #1;
    check("id_ready_after_reset", id_ready, 1'b1);

    foreach (vecs[i]) begin
      drive_id(vecs[i]);
      id_valid = 1'b1;
      #1;
      check($sformatf("id_ready_vec%0d", i), id_ready, 1'b1);
      sb_q.push_back(vecs[i].want);
      tick();
      id_valid = 1'b0; wb_valid = 1'b0;
      lat = 1;
      while (!ex_valid && lat < 20) begin
        check($sformatf("busy_wait_vec%0d", i), {ex_busy, id_ready}, 2'b10);
        tick();
        lat++;
      end
      check($sformatf("latency_vec%0d", i), lat, vecs[i].lat);
      check($sformatf("busy_clear_vec%0d", i), ex_busy, 1'b0);
      tick();
      check($sformatf("empty_after_vec%0d", i), ex_valid, 1'b0);
    end

    // Held ADD with register B: writeback to rs2 updates the held operand.
    v = mk(0, 5, 32'd1, 6, 32'd2, 0, 0, 0, 0, 0, 9, 0, 32'd1, 32'd2, 5'b10000, 1);
    drive_id(v); id_valid = 1'b1; ex_ready = 1'b0;
    sb_q.push_back(v.want);
    tick();
    id_valid = 1'b0;
    check("hold_b_before_snoop", {ex_valid, ex_b}, {1'b1, 32'd2});
    wb_valid = 1'b1; wb_rd = 5'd6; wb_data = 32'h55;
    #1;
    check("id_ready_backpressure", id_ready, 1'b0);
    tick();
    wb_valid = 1'b0;
    check("snoop_b", {ex_valid, ex_b}, {1'b1, 32'h55});
    tick();
    check("snoop_b_stable", {ex_valid, ex_op, ex_a, ex_b}, {1'b1, 4'd0, 32'd1, 32'h55});
    sb_q[0].b = 32'h55;
    ex_ready = 1'b1;
    tick();
    check("snoop_b_consumed", ex_valid, 1'b0);

    // Held ADD with immediate B: rs2 writes leave B alone, rs1 writes update A.
    v = mk(0, 5, 32'd1, 6, 32'd2, 1, 32'h77, 0, 0, 0, 9, 0, 32'd1, 32'h77, 5'b10000, 1);
    drive_id(v); id_valid = 1'b1; ex_ready = 1'b0;
    sb_q.push_back(v.want);
    tick();
    id_valid = 1'b0;
    wb_valid = 1'b1; wb_rd = 5'd6; wb_data = 32'h55;
    tick();
    check("imm_b_kept", {ex_valid, ex_b}, {1'b1, 32'h77});
    wb_rd = 5'd5; wb_data = 32'h66;
    tick();
    wb_valid = 1'b0;
    check("snoop_a", {ex_a, ex_b}, {32'h66, 32'h77});
    sb_q[0].a = 32'h66;
    ex_ready = 1'b1;
    tick();
    check("imm_consumed", ex_valid, 1'b0);

    // Flush in the first MUL_WAIT cycle, with an ID transfer offered alongside.
    v = mk(7, 1, 32'd3, 2, 32'd4, 0, 0, 0, 0, 0, 3, 7, 32'd3, 32'd4, 5'b10000, MUL_LAT);
    drive_id(v); id_valid = 1'b1;
    tick();
    check("mul_busy_before_flush", {ex_busy, ex_valid}, 2'b10);
    drive_id(vecs[0]); flush = 1'b1;
    tick();
    flush = 1'b0; id_valid = 1'b0;
    check("flush_kills", {ex_valid, ex_busy, id_ready}, 3'b001);
    repeat (3) begin
      tick();
      check("no_valid_after_flush", ex_valid, 1'b0);
    end

    // Reset in the first MUL_WAIT cycle.
    drive_id(v); id_valid = 1'b1;
    tick();
    id_valid = 1'b0;
    check("mul_busy_before_reset", ex_busy, 1'b1);
    reset_n = 1'b0;
    #1;
    check("reset_mid_mul_comb", all_outputs(), '0);
    tick();
    check("reset_mid_mul_reg", all_outputs(), '0);
    reset_n = 1'b1;
    #1;
    check("reset_release_ready", {id_ready, ex_valid, ex_busy}, 3'b100);
    tick();
    check("no_valid_after_reset", ex_valid, 1'b0);

    // Four back-to-back ADDs with EX always ready.
    pat = '0;
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin
        v = mk(0, 5'(k + 1), 32'(100 + k), 5'(k + 10), 32'(200 + k), 0, 0, 0, 0, 0,
               5'(k + 20), 0, 32'(100 + k), 32'(200 + k), 5'b10000, 1);
        drive_id(v); id_valid = 1'b1;
        sb_q.push_back(v.want);
      end else begin
        id_valid = 1'b0;
      end
      tick();
      pat[k] = ex_valid;
    end
    check("b2b_valid_pattern", pat, 6'b001111);
    check("scoreboard_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/ex_issue.md
# ex_issue

Decode-to-execute issue register for the 2-stage core. It captures one decoded instruction from ID and resolves operands, forwarding from the writeback port and snooping it while the instruction is held. It then drives stable operands and the op select into the combinational EX arithmetic: adder, subtractor, slt/sltu, shifters and multiplier. Multiply ops hold their operands for `MUL_LAT` cycles so the deep multiplier array can be timed as a multicycle path.

## Interface
- `XLEN`, 32: operand width; only 32 is supported.
- `MUL_LAT`, 2: cycles multiply operands are held before `ex_valid`; legal range 1..4.

- `clock`, in, 1: single clock; all state updates on the rising edge.
- `reset_n`, in, 1: reset is synchronous and active-low.
- `flush`, in, 1: synchronous kill of the held instruction.
- `id_valid`, in, 1: ID presents an instruction.
- `id_ready`, out, 1: issue register can accept this cycle.
- `id_op`, in, 4: op code, listed under Operation.
- `id_rs1_idx`, in, 5: source register 1 index.
- `id_rs2_idx`, in, 5: source register 2 index.
- `id_rs1_val`, in, 32: register file value for rs1.
- `id_rs2_val`, in, 32: register file value for rs2.
- `id_use_imm`, in, 1: operand B comes from `id_imm` instead of rs2.
- `id_imm`, in, 32: sign-extended immediate.
- `id_rd`, in, 5: destination register index.
- `id_rd_wen`, in, 1: instruction writes rd.
- `wb_valid`, in, 1: writeback port valid.
- `wb_rd`, in, 5: writeback register index.
- `wb_data`, in, 32: writeback data.
- `ex_valid`, out, 1: EX result is valid this cycle.
- `ex_ready`, in, 1: EX/WB consumes the result.
- `ex_busy`, out, 1: multiply operands are being held and are not yet valid.
- `ex_op`, out, 4: registered op code.
- `ex_a`, out, 32: registered operand A.
- `ex_b`, out, 32: registered operand B.
- `ex_rd`, out, 5: registered rd.
- `ex_rd_wen`, out, 1: registered write enable.
- `ex_signed_a`, out, 1: multiplier sign control for operand A.
- `ex_signed_b`, out, 1: multiplier sign control for operand B.
- `ex_mul_hi`, out, 1: select the upper 32 bits of the 64-bit product.
- `ex_illegal`, out, 1: op code is reserved.

## Operation
- Op codes:
  - 0 ADD, 1 SUB, 2 SLT, 3 SLTU, 4 SLL, 5 SRL, 6 SRA.
  - 7 MUL: `ex_signed_a`=0, `ex_signed_b`=0, `ex_mul_hi`=0.
  - 8 MULH: `ex_signed_a`=1, `ex_signed_b`=1, `ex_mul_hi`=1.
  - 9 MULHSU: `ex_signed_a`=1, `ex_signed_b`=0, `ex_mul_hi`=1.
  - 10 MULHU: `ex_signed_a`=0, `ex_signed_b`=0, `ex_mul_hi`=1.
  - Non-multiply ops drive `ex_signed_a`, `ex_signed_b` and `ex_mul_hi` to 0.
  - 11..15 are reserved: they issue as ADD with `ex_illegal`=1 and `ex_rd_wen` forced to 0.
- FSM states are EMPTY, ALU_HOLD and MUL_WAIT.
  - EMPTY, on accept: a non-multiply op goes to ALU_HOLD; a multiply op goes to MUL_WAIT with counter = `MUL_LAT`-1. With `MUL_LAT`=1, a multiply op goes directly to ALU_HOLD.
  - MUL_WAIT: the counter decrements each cycle. At 0 the state becomes ALU_HOLD.
  - ALU_HOLD: `ex_valid`=1. When `ex_ready` is high, the state goes to EMPTY, or reloads if ID is accepted in the same cycle.
- `id_ready` = `reset_n` & (EMPTY | (ALU_HOLD & `ex_ready`)). It is low throughout MUL_WAIT.
- Operand capture: A = rs1; B = `id_use_imm` ? imm : rs2.
  - If `wb_valid`, `wb_rd` == idx and idx != 0, the register value is replaced by `wb_data`.
  - Index 0 always reads 0, regardless of `id_rs*_val`.
- Snoop: while occupied and not yet consumed, a matching `wb_valid` write overwrites the held A. It also overwrites the held B when `use_imm`=0. Index 0 is never updated.
  - In MUL_WAIT, a snoop update restarts the counter at `MUL_LAT`-1.
- Flush: the state goes to EMPTY and any ID transfer in the same cycle is dropped. Reset takes priority over flush, and flush over capture.

## Timing
- Reset values: every output is 0 while `reset_n`=0, including `id_ready`. In the first cycle after reset release, `id_ready`=1.
- Non-multiply op: accepted at edge N, `ex_valid`=1 in cycle N+1.
- Multiply op: accepted at edge N.
  - `ex_busy`=1 in cycles N+1 .. N+`MUL_LAT`-1.
  - `ex_valid`=1 from cycle N+`MUL_LAT`.
  - `ex_a` and `ex_b` stay constant from N+1 until consumption, unless a snoop update occurs.
- Back-to-back: when `ex_valid` & `ex_ready` & `id_valid` are all high in one cycle, the next instruction is valid in the following cycle with no bubble.
- Backpressure: while `ex_valid`=1 and `ex_ready`=0, all ex_* outputs hold stable.
- Reset or flush mid-MUL_WAIT: the state is EMPTY on the next cycle and no `ex_valid` is produced.

## Test plan
- Reset, then release `reset_n`; accept ADD with rs1=x1=5 and rs2=x2=7 → next cycle `ex_valid`=1, `ex_a`=5, `ex_b`=7, `ex_op`=0.
- Same cycle `wb_valid`, `wb_rd`=1, `wb_data`=0x100; accept SUB with rs1=x1 (`id_rs1_val`=3) → `ex_a`=0x100. Repeat with rs1=x0 and `wb_rd`=0 → `ex_a`=0.
- MULHSU with `MUL_LAT`=2, a=0xFFFFFFFF, b=2 → `ex_busy`=1 for 1 cycle, then `ex_valid`=1 with `ex_signed_a`=1, `ex_signed_b`=0, `ex_mul_hi`=1, and `id_ready`=0 during the wait.
- Hold ADD with `ex_ready`=0 for 3 cycles while WB writes the held rs2 index with 0x55 → `ex_b`=0x55 from the cycle after the write; an immediate-B op keeps its imm.
- Assert flush in cycle 1 of MUL_WAIT → no `ex_valid`, `id_ready`=1 next cycle. Repeat the same sequence with `reset_n`=0 → all outputs 0.
- `id_op`=12 → `ex_illegal`=1, `ex_rd_wen`=0. Then send 4 back-to-back ADDs with `ex_ready`=1 → 4 consecutive `ex_valid` cycles.
